// File: rtl/mem_stage_pkg.sv
// +-----------------------------------------------------------------------+
// | mem_stage_pkg : shared CPU types/constants for the memory stage        |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

  // Operand forwarding source selects used by the EX stage muxes.
  localparam logic [1:0] FWD_FROM_RF  = 2'd0;
  localparam logic [1:0] FWD_FROM_MEM = 2'd1;
  localparam logic [1:0] FWD_FROM_WB  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +-----------------------------------------------------------------------+
// | mem_lane_align : store byte-lane steering and load extract/extend      |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  st_lo,
  input  mem_size_t   st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_lo,
  input  mem_size_t   ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_be      = 4'b1111;
    st_wdata   = st_data;
    misaligned = |st_lo;
    case (st_size)
      MEM_BYTE: begin
        st_be      = BIG_ENDIAN ? (4'b1000 >> st_lo) : (4'b0001 << st_lo);
        st_wdata   = {4{st_data[7:0]}};
        misaligned = 1'b0;
      end
      MEM_HALF: begin
        st_be      = (st_lo[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
        st_wdata   = {2{st_data[15:0]}};
        misaligned = st_lo[0];
      end
      default: ;
    endcase
  end

  // Big-endian puts address 0 in the top lane, so the lane index is inverted.
  always_comb begin
    byte_lane = BIG_ENDIAN ? ~ld_lo : ld_lo;
    half_hi   = ld_lo[1] ^ BIG_ENDIAN;
    byte_v    = rdata[{byte_lane, 3'b000} +: 8];
    half_v    = half_hi ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      MEM_BYTE: ld_data = {{24{~ld_unsigned & byte_v[7]}}, byte_v};
      MEM_HALF: ld_data = {{16{~ld_unsigned & half_v[15]}}, half_v};
      default:  ld_data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +-----------------------------------------------------------------------+
// | mem_stage : pipeline MEM stage, data-memory handshake and WB register  |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_result_2,
  input  logic        load_inst,
  input  logic        store_inst,
  input  mem_size_t   mem_size,
  input  logic        load_unsigned,
  input  logic [4:0]  dest_reg,
  input  logic        dest_reg_valid,
  output logic        stall,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic        dm_rd,
  output logic        dm_wr,
  input  logic        dm_waitrequest,
  input  logic [31:0] dm_rdata,
  input  logic        dm_rdata_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest_reg,
  output logic        wb_dest_reg_valid,
  output logic        wb_valid,
  output logic        addr_err
);

  mem_state_t  state, state_n;
  logic        is_load;
  logic [1:0]  lo_q;
  mem_size_t   size_q;
  logic        uns_q;
  logic [4:0]  dest_q;
  logic        dest_valid_q;

  logic        accept, mem_op, ld_done, st_done;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        misaligned;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .st_lo       (ex_result[1:0]),
    .st_size     (mem_size),
    .st_data     (ex_result_2),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .misaligned  (misaligned),
    .ld_lo       (lo_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .rdata       (dm_rdata),
    .ld_data     (ld_data)
  );

  assign stall = (state != ST_IDLE);
  assign dm_rd = (state == ST_REQ) &  is_load;
  assign dm_wr = (state == ST_REQ) & ~is_load;

  always_comb begin
    state_n = state;
    accept  = in_valid && (state == ST_IDLE);
    mem_op  = load_inst | store_inst;
    ld_done = 1'b0;
    st_done = 1'b0;
    case (state)
      ST_IDLE: if (accept && mem_op && !misaligned) state_n = ST_REQ;
      ST_REQ: begin
        if (!dm_waitrequest) begin
          if (!is_load) begin
            st_done = 1'b1;
            state_n = ST_IDLE;
          end else if (dm_rdata_valid) begin
            ld_done = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dm_rdata_valid) begin
          ld_done = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      is_load           <= 1'b0;
      lo_q              <= 2'b00;
      size_q            <= MEM_BYTE;
      uns_q             <= 1'b0;
      dest_q            <= 5'd0;
      dest_valid_q      <= 1'b0;
      dm_addr           <= 32'd0;
      dm_wdata          <= 32'd0;
      dm_be             <= 4'd0;
      wb_result         <= 32'd0;
      wb_dest_reg       <= 5'd0;
      wb_dest_reg_valid <= 1'b0;
      wb_valid          <= 1'b0;
      addr_err          <= 1'b0;
    end else begin
      state    <= state_n;
      wb_valid <= 1'b0;
      addr_err <= 1'b0;
      if (accept) begin
        if (!mem_op) begin
          wb_result         <= ex_result;
          wb_dest_reg       <= dest_reg;
          wb_dest_reg_valid <= dest_reg_valid;
          wb_valid          <= 1'b1;
        end else if (misaligned) begin
          addr_err <= 1'b1;
        end else begin
          dm_addr      <= {ex_result[31:2], 2'b00};
          dm_wdata     <= st_wdata;
          dm_be        <= st_be;
          is_load      <= load_inst;
          lo_q         <= ex_result[1:0];
          size_q       <= mem_size;
          uns_q        <= load_unsigned;
          dest_q       <= dest_reg;
          dest_valid_q <= dest_reg_valid;
        end
      end
      if (ld_done) begin
        wb_result         <= ld_data;
        wb_dest_reg       <= dest_q;
        wb_dest_reg_valid <= dest_valid_q;
        wb_valid          <= 1'b1;
      end
      // A store retires with no register write; result and dest are left alone.
      if (st_done) begin
        wb_dest_reg_valid <= 1'b0;
        wb_valid          <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: BIG_ENDIAN, 1, byte-lane order (1 = address 0 on bits 31:24; 0 = address 0 on bits 7:0).
REQ-002 SHALL have ports, one per line:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds an instruction.
- ex_result  in  32  ALU result: effective address for load/store, writeback value otherwise.
- ex_result_2  in  32  forwarded B operand, used as store data.
- load_inst, store_inst  in  1 each  memory-op flags.
- mem_size  in  2  mem_size_t: BYTE, HALF, WORD.
- load_unsigned  in  1  zero-extend (1) or sign-extend (0) sub-word loads.
- dest_reg  in  5  writeback register.
- dest_reg_valid  in  1  writeback enabled.
- stall  out  1  upstream holds EX/MEM contents.
- dm_addr  out  32  word-aligned address {ex_result[31:2],2'b0}.
- dm_wdata  out  32  lane-replicated store data.
- dm_be  out  4  byte enables.
- dm_rd, dm_wr  out  1 each  read/write request.
- dm_waitrequest  in  1  memory not accepting the request.
- dm_rdata  in  32  read data.
- dm_rdata_valid  in  1  read data valid.
- wb_result  out  32  registered value to WB; also the MEM/WB forwarding source.
- wb_dest_reg  out  5  registered destination.
- wb_dest_reg_valid  out  1  registered write enable.
- wb_valid  out  1  MEM/WB slot valid.
- addr_err  out  1  one-cycle pulse on misaligned access.

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT; accept an instruction only when in_valid and state IDLE.
REQ-004 SHALL assert stall combinationally whenever state is not IDLE.
REQ-005 Non-memory op accepted: SHALL load wb_result=ex_result, wb_dest_*=inputs, wb_valid=1 at next edge (latency 1); state stays IDLE.
REQ-006 Load/store accepted: SHALL register address, data, be, size, unsigned and dest; go to REQ; dm_rd/dm_wr driven from registers only in REQ.
REQ-007 In REQ, SHALL hold dm_* stable while dm_waitrequest=1; on dm_waitrequest=0, store goes to IDLE and load goes to WAIT, or directly to IDLE when dm_rdata_valid is also 1 that cycle.
REQ-008 Load complete (dm_rdata_valid in WAIT or per REQ-007): SHALL write the extracted, extended data to wb_result with wb_valid=1 at that edge.
REQ-009 Store complete: SHALL pulse wb_valid=1 with wb_dest_reg_valid=0.
REQ-010 wb_valid SHALL be 0 in every cycle with no completion; wb_result/wb_dest_reg hold their last value.
REQ-011 BIG_ENDIAN=1 SHALL use be: BYTE 4'b1000>>a[1:0]; HALF a[1]?0011:1100; WORD 1111. BIG_ENDIAN=0 SHALL use be: BYTE 0001<<a[1:0]; HALF a[1]?1100:0011. dm_wdata SHALL be {4{b}}, {2{h}} or the word.
REQ-012 Misaligned access (HALF with a[0]=1; WORD with a[1:0]!=0) SHALL issue no dm request, pulse addr_err next cycle with wb_valid=0, and stay IDLE.
REQ-013 dm_rdata_valid outside WAIT or REQ SHALL be ignored.

Reset
REQ-014 reset_n low SHALL asynchronously force state IDLE, stall=0, dm_rd=dm_wr=0, dm_be=0, wb_valid=0, wb_dest_reg_valid=0, addr_err=0, and wb_result, wb_dest_reg, dm_addr, dm_wdata to 0.
REQ-015 Reset mid-transaction SHALL abandon the access; no late response SHALL produce wb_valid after reset.

Structure
REQ-016 mem_size_t and the FWD_FROM_* forwarding constants SHALL live in the shared CPU package.
REQ-017 Byte-lane steering and load extension SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-018 Bench SHALL cover:
- ALU op, ex_result=0x1234_5678, dest 5 -> next cycle wb_valid=1, wb_result=0x1234_5678, stall never 1.
- BIG_ENDIAN=1, LB signed, addr 0x...01, rdata 0x0080_0000, waitrequest 2 cycles, rdata 3 cycles later -> be=0100, stall held, wb_result=0xFFFF_FF80.
- SH addr 0x...02, data 0x0000_BEEF, BIG_ENDIAN=1 -> be=0011, wdata=0xBEEF_BEEF, wb_valid pulse with dest_reg_valid=0.
- LW addr 0x...06 -> no dm_rd, addr_err pulse, wb_valid=0.
- Load in WAIT, reset_n low for 1 cycle, rdata_valid arrives after -> all outputs 0, no wb_valid.
- LW, waitrequest=0 with rdata_valid=1 in the same REQ cycle -> completes, stall high exactly 1 cycle.
